// File: rtl/exhaustive_stim_sequencer.sv
// exhaustive_stim_sequencer
//   Walks a gate-level circuit's primary inputs through every combination
//   0 .. 2**N_IN-1. Each vector is held for SETTLE cycles so that gate delays
//   can propagate. The circuit response is then captured and offered to a
//   logger as {vector, response, stability flag} over a valid/ready handshake.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        begin a sweep (sampled in IDLE only)
//   abort        stop a sweep from any non-IDLE state
//   stim_o       circuit primary inputs (MSB = first input)
//   resp_i       circuit outputs
//   cap_valid    capture record presented
//   cap_ready    logger accepts record
//   cap_vec      vector that produced the record
//   cap_resp     resp_i sampled at the capture edge
//   cap_unstable resp_i changed between the last two settle cycles
//   busy         high in SETTLE and CAPTURE
//   done         one-cycle pulse after the final record is accepted
module exhaustive_stim_sequencer #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  stim_o,
  input  logic [N_OUT-1:0] resp_i,
  output logic             cap_valid,
  input  logic             cap_ready,
  output logic [N_IN-1:0]  cap_vec,
  output logic [N_OUT-1:0] cap_resp,
  output logic             cap_unstable,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DONE} state_t;

  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [7:0]      CNT_LOAD = 8'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_OUT-1:0] resp_prev_q, resp_prev_d;
  logic             cap_valid_q, cap_valid_d;
  logic [N_IN-1:0]  cap_vec_q, cap_vec_d;
  logic [N_OUT-1:0] cap_resp_q, cap_resp_d;
  logic             cap_unst_q, cap_unst_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      resp_prev_q <= '0;
      cap_valid_q <= 1'b0;
      cap_vec_q   <= '0;
      cap_resp_q  <= '0;
      cap_unst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      resp_prev_q <= resp_prev_d;
      cap_valid_q <= cap_valid_d;
      cap_vec_q   <= cap_vec_d;
      cap_resp_q  <= cap_resp_d;
      cap_unst_q  <= cap_unst_d;
    end
  end

  // The vector counter doubles as the stimulus register: it is held in IDLE,
  // cleared on abort and on start, so stim_o needs no separate flop.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    resp_prev_d = resp_prev_q;
    cap_valid_d = cap_valid_q;
    cap_vec_d   = cap_vec_q;
    cap_resp_d  = cap_resp_q;
    cap_unst_d  = cap_unst_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_SETTLE;
          vec_d   = '0;
          cnt_d   = CNT_LOAD;
        end
      end

      ST_SETTLE: begin
        resp_prev_d = resp_i;
        if (abort) begin
          state_d     = ST_IDLE;
          vec_d       = '0;
          cap_valid_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d     = ST_CAPTURE;
          cap_resp_d  = resp_i;
          cap_vec_d   = vec_q;
          cap_unst_d  = (resp_i != resp_prev_q);
          cap_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_CAPTURE: begin
        if (abort) begin
          state_d     = ST_IDLE;
          vec_d       = '0;
          cap_valid_d = 1'b0;
        end else if (cap_ready) begin
          cap_valid_d = 1'b0;
          if (vec_q != VEC_LAST) begin
            state_d = ST_SETTLE;
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (abort) begin
          vec_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign stim_o       = vec_q;
  assign cap_valid    = cap_valid_q;
  assign cap_vec      = cap_vec_q;
  assign cap_resp     = cap_resp_q;
  assign cap_unstable = cap_unst_q;
  assign busy         = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign done         = (state_q == ST_DONE);

endmodule
